// File: rtl/capture_ctrl_mc.sv
// Multi-channel capture controller: decimated circular RAM writes, armed edge/auto-roll trigger,
// oldest-first trace dump over valid/ready. Define CAPMC_AUTOROLL_EN to build the auto-roll mode (11).
module capture_ctrl_mc #(
  parameter int ADDR_W = 9,
  parameter int NUM_CH = 4,
  parameter int SMPL_W = 8,
  parameter int DEC_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         trig_in,
  input  logic [$clog2(NUM_CH)-1:0] trig_sel,
  input  logic [1:0]                trig_mode,
  input  logic [ADDR_W-1:0]         trig_pos,
  input  logic [3:0]                dec_pwr,
  input  logic                      start,
  input  logic                      dump_start,
  input  logic                      dump_ready,
  input  logic [SMPL_W-1:0]         ram_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      armed,
  output logic                      capture_done,
  output logic                      busy,
  output logic                      dump_valid,
  output logic                      dump_last,
  output logic [SMPL_W-1:0]         dump_data
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {IDLE, SAMPLE, DUMP_RD, DUMP_SEND} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trace_end_q, trace_end_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic              trig_seen_q, trig_seen_d;
  logic              post_act_q, post_act_d;
  logic              trig_cur_q, trig_cur_d;
  logic              trig_prev_q, trig_prev_d;
  logic [SMPL_W-1:0] dump_data_q, dump_data_d;

  logic [DEC_W-1:0]  dec_lim;
  logic [ADDR_W-1:0] arm_lvl;
  logic              keep, mode_ok, start_ok, edge_hit;

`ifdef CAPMC_AUTOROLL_EN
  assign mode_ok = (trig_mode != 2'b00);
`else
  assign mode_ok = (trig_mode == 2'b01) || (trig_mode == 2'b10);
`endif

  assign start_ok = start && mode_ok;
  assign dec_lim  = (DEC_W'(1) << dec_pwr) - DEC_W'(1);
  assign keep     = (state_q == SAMPLE) && (dec_cnt_q == dec_lim);
  // Arm once the RAM holds enough history that trig_pos post samples complete a full trace.
  assign arm_lvl  = ADDR_MAX - trig_pos;
  assign edge_hit = (trig_mode == 2'b01) ? ( trig_cur_q & ~trig_prev_q) :
                    (trig_mode == 2'b10) ? (~trig_cur_q &  trig_prev_q) : 1'b0;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trace_end_d = trace_end_q;
    rd_ptr_d    = rd_ptr_q;
    dec_cnt_d   = dec_cnt_q;
    armed_d     = armed_q;
    done_d      = done_q;
    trig_seen_d = trig_seen_q;
    post_act_d  = post_act_q;
    dump_data_d = dump_data_q;
    trig_prev_d = trig_cur_q;
    trig_cur_d  = trig_in[0];
    for (int i = 1; i < NUM_CH; i++)
      if (trig_sel == SEL_W'(i)) trig_cur_d = trig_in[i];

    if (start_ok && (state_q == IDLE || state_q == SAMPLE)) begin
      state_d     = SAMPLE;
      addr_d      = '0;
      dec_cnt_d   = '0;
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      done_d      = 1'b0;
      armed_d     = 1'b0;
      trig_seen_d = 1'b0;
      post_act_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start && done_q) begin
            state_d  = DUMP_RD;
            rd_ptr_d = trace_end_q + ADDR_W'(1);
          end
        end
        SAMPLE: begin
          dec_cnt_d = keep ? '0 : dec_cnt_q + DEC_W'(1);
          if (armed_q && edge_hit) trig_seen_d = 1'b1;
          if (keep) begin
            addr_d = addr_q + ADDR_W'(1);
            if (post_act_q || trig_seen_q) begin
              post_act_d = 1'b1;
              post_cnt_d = post_act_q ? post_cnt_q + ADDR_W'(1) : '0;
              if (post_cnt_d == trig_pos) begin
                trace_end_d = addr_q;
                done_d      = 1'b1;
                armed_d     = 1'b0;
                state_d     = IDLE;
              end
            end else begin
              if (pre_cnt_q != ADDR_MAX) pre_cnt_d = pre_cnt_q + ADDR_W'(1);
              if (pre_cnt_q >= arm_lvl) armed_d = 1'b1;
            end
          end
`ifdef CAPMC_AUTOROLL_EN
          if (trig_mode == 2'b11 && armed_d) trig_seen_d = 1'b1;
`endif
        end
        DUMP_RD: begin
          state_d     = DUMP_SEND;
          dump_data_d = ram_rdata;
        end
        DUMP_SEND: begin
          if (dump_ready) begin
            if (rd_ptr_q == trace_end_q) begin
              done_d  = 1'b0;
              state_d = IDLE;
            end else begin
              rd_ptr_d = rd_ptr_q + ADDR_W'(1);
              state_d  = DUMP_RD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trace_end_q <= '0;
      rd_ptr_q    <= '0;
      dec_cnt_q   <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      trig_seen_q <= 1'b0;
      post_act_q  <= 1'b0;
      trig_cur_q  <= 1'b0;
      trig_prev_q <= 1'b0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trace_end_q <= trace_end_d;
      rd_ptr_q    <= rd_ptr_d;
      dec_cnt_q   <= dec_cnt_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      trig_seen_q <= trig_seen_d;
      post_act_q  <= post_act_d;
      trig_cur_q  <= trig_cur_d;
      trig_prev_q <= trig_prev_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign ram_en       = keep || (state_q == DUMP_RD);
  assign ram_we       = keep;
  assign ram_addr     = (state_q == DUMP_RD || state_q == DUMP_SEND) ? rd_ptr_q : addr_q;
  assign armed        = armed_q;
  assign capture_done = done_q;
  assign busy         = (state_q != IDLE);
  assign dump_valid   = (state_q == DUMP_SEND);
  assign dump_last    = (state_q == DUMP_SEND) && (rd_ptr_q == trace_end_q);
  assign dump_data    = dump_data_q;
endmodule

// File: tb/tb_capture_ctrl_mc.sv
// Directed bench for capture_ctrl_mc (16-deep RAM): capture, arming, decimation, restart,
// dump with and without backpressure, auto-roll / mode-11 handling, and reset mid-dump.
module tb_capture_ctrl_mc;
  logic       clk;
  logic       rst_n;
  logic [3:0] trig_in;
  logic [1:0] trig_sel;
  logic [1:0] trig_mode;
  logic [3:0] trig_pos;
  logic [3:0] dec_pwr;
  logic       start, dump_start, dump_ready;
  logic [7:0] ram_rdata;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic       armed, capture_done, busy, dump_valid, dump_last;
  logic [7:0] dump_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16];
  logic [7:0] smp = 8'h00;
  logic [3:0] addr_log [$];
  logic [7:0] data_log [$];

  capture_ctrl_mc #(.ADDR_W(4), .NUM_CH(4), .SMPL_W(8), .DEC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .trig_sel(trig_sel),
    .trig_mode(trig_mode), .trig_pos(trig_pos), .dec_pwr(dec_pwr),
    .start(start), .dump_start(dump_start), .dump_ready(dump_ready),
    .ram_rdata(ram_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .armed(armed), .capture_done(capture_done), .busy(busy),
    .dump_valid(dump_valid), .dump_last(dump_last), .dump_data(dump_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: the sample bus is a free-running counter; read data is presented by the end of the read cycle.
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= smp;
      addr_log.push_back(ram_addr);
      data_log.push_back(smp);
    end
    smp <= smp + 8'd1;
  end

  initial ram_rdata = 8'h00;
  always @(negedge clk)
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 32'({ram_en, ram_we, armed, capture_done, busy, dump_valid, dump_last}), 0);
    chk({tag, "_addr_data"}, 32'({ram_addr, dump_data}), 0);
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
  endtask

  // Expected dump = the last 16 written samples, in write order.
  task automatic dump_rx(input bit bp, input int first_addr);
    int w;
    int base;
    logic [7:0] exp;
    base = data_log.size() - 16;
    dump_ready = !bp;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    chk("dump_rd_addr", 32'(ram_addr), first_addr);
    chk("dump_rd_en_we", 32'({ram_en, ram_we}), 2);
    for (int i = 0; i < 16; i++) begin
      w = 0;
      while (!dump_valid && w < 8) begin tick(); w++; end
      chk("dump_latency", w, 1);
      exp = (base + i >= 0) ? data_log[base + i] : 8'hxx;
      chk("dump_data", 32'(dump_data), 32'(exp));
      chk("dump_last", 32'(dump_last), 32'(i == 15));
      if (bp) begin
        if (i == 3) start = 1'b1;
        tick(); start = 1'b0;
        chk("bp_hold_data", 32'(dump_data), 32'(exp));
        chk("bp_hold_valid", 32'(dump_valid), 1);
        dump_ready = 1'b1;
      end
      tick();
      if (bp) dump_ready = 1'b0;
    end
    chk("dump_done_clr", 32'(capture_done), 0);
    chk("dump_busy_drop", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; trig_in = 4'b0; trig_sel = 2'd0; trig_mode = 2'b00; trig_pos = 4'd4;
    dec_pwr = 4'd0; start = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // mode 00 ignores start
    start = 1'b1; tick(); start = 1'b0;
    chk("mode00_ignored", 32'(busy), 0);

    // basic rising capture, trig_pos = 4
    trig_mode = 2'b01;
    start = 1'b1; tick(); start = 1'b0;
    clear_logs();
    chk("t1_first_we", 32'(ram_we), 1);
    chk("t1_first_addr", 32'(ram_addr), 0);
    chk("t1_busy", 32'(busy), 1);
    repeat (11) tick();
    chk("t1_not_armed_w11", 32'(armed), 0);
    tick();
    chk("t1_armed_w12", 32'(armed), 1);
    repeat (8) tick();
    trig_in = 4'b0001;
    repeat (6) tick();
    chk("t1_done_early", 32'(capture_done), 0);
    chk("t1_last_we", 32'(ram_we), 1);
    chk("t1_last_addr", 32'(ram_addr), 10);
    tick();
    chk("t1_done", 32'(capture_done), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_disarm", 32'(armed), 0);
    chk("t1_nwrites", addr_log.size(), 27);
    for (int k = 0; k < 27 && k < addr_log.size(); k++)
      chk("t1_waddr", 32'(addr_log[k]), k % 16);

    // full dump, ready held high; trace_end = 10
    trig_in = 4'b0;
    dump_rx(1'b0, 11);
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    chk("dump_start_ignored", 32'(busy), 0);

    // decimation by 8
    dec_pwr = 4'd3;
    start = 1'b1; tick(); start = 1'b0;
    clear_logs();
    for (int i = 0; i < 140; i++) begin
      chk("dec_we", 32'(ram_we), 32'(i % 8 == 7));
      if (i == 127) chk("dec_addr15", 32'(ram_addr), 15);
      if (i == 135) chk("dec_wrap0", 32'(ram_addr), 0);
      tick();
    end

    // restart mid-SAMPLE on channel 2, early edge ignored
    start = 1'b1; dec_pwr = 4'd0; trig_sel = 2'd2; tick(); start = 1'b0;
    clear_logs();
    chk("restart_addr", 32'(ram_addr), 0);
    chk("restart_we", 32'(ram_we), 1);
    chk("restart_armed_clr", 32'(armed), 0);
    repeat (3) tick(); trig_in = 4'b0100;
    repeat (2) tick(); trig_in = 4'b0000;
    repeat (9) tick();
    chk("t4_armed", 32'(armed), 1);
    trig_in = 4'b0001;
    repeat (2) tick(); trig_in = 4'b0000;
    repeat (6) tick();
    chk("early_edge_ignored", 32'(capture_done), 0);
    chk("other_ch_ignored", 32'(busy), 1);
    repeat (2) tick(); trig_in = 4'b0100;
    repeat (6) tick();
    chk("t4_done_early", 32'(capture_done), 0);
    chk("t4_last_addr", 32'(ram_addr), 14);
    tick();
    chk("t4_done", 32'(capture_done), 1);

    // backpressured dump, start pulse during a stall; trace_end = 14
    trig_in = 4'b0;
    dump_rx(1'b1, 15);

`ifdef CAPMC_AUTOROLL_EN
    // auto-roll with trig_pos = 0: trigger sample right after arming
    trig_mode = 2'b11; trig_pos = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    chk("ar_not_armed", 32'(armed), 0);
    tick();
    chk("ar_armed", 32'(armed), 1);
    chk("ar_done_early", 32'(capture_done), 0);
    chk("ar_trig_addr", 32'(ram_addr), 0);
    tick();
    chk("ar_done", 32'(capture_done), 1);
`else
    // mode 11 is off in this build; then rising with trig_pos = 0
    trig_mode = 2'b11; trig_pos = 4'd0; trig_sel = 2'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("mode11_ignored", 32'(busy), 0);
    trig_mode = 2'b01;
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    chk("tp0_not_armed", 32'(armed), 0);
    tick();
    chk("tp0_armed", 32'(armed), 1);
    trig_in = 4'b0001;
    repeat (2) tick();
    chk("tp0_done_early", 32'(capture_done), 0);
    chk("tp0_trig_addr", 32'(ram_addr), 2);
    tick();
    chk("tp0_done", 32'(capture_done), 1);
    trig_in = 4'b0;
`endif

    // asynchronous reset in the middle of a dump
    dump_ready = 1'b0;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    tick();
    chk("rst_pre_valid", 32'(dump_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid_dump");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
